sv32_ptw: RTL
=============

SV32_PTW -- requirements
Module: sv32_ptw

Interface
- REQ-001: The module SHALL have one clock, `clk`, and an asynchronous active-low reset, `resetn`.
- REQ-002: clk  in  1  sole clock, rising edge.
- REQ-003: resetn  in  1  asynchronous active-low reset.
- REQ-004: flush  in  1  abort the walk in progress (sfence.vma).
- REQ-005: req_valid  in  1  TLB miss; a walk is requested.
- REQ-006: req_ready  out  1  high only in IDLE.
- REQ-007: req_vpn  in  20  virtual page number {vpn1, vpn0}.
- REQ-008: req_asid  in  9  current ASID.
- REQ-009: satp_ppn  in  22  root page-table PPN.
- REQ-010: mem_valid  out  1  PTE read request.
- REQ-011: mem_addr  out  34  physical PTE address.
- REQ-012: mem_ready  in  1  read complete; mem_rdata is valid in this cycle.
- REQ-013: mem_rdata  in  32  PTE word.
- REQ-014: tlb_we  out  1  TLB fill strobe.
- REQ-015: tlb_tag  out  29  {asid, vpn}.
- REQ-016: tlb_payload  out  32  leaf PTE, normalised to 4 KiB.
- REQ-017: resp_valid  out  1  one-cycle completion pulse.
- REQ-018: resp_fault  out  1  page fault; qualified by resp_valid.

Function
- REQ-019: The FSM SHALL have exactly four states.
  - IDLE -> L1 on req_valid && req_ready.
  - L1 -> L0 on a valid non-leaf response.
  - L1 -> RESP on a leaf or a fault.
  - L0 -> RESP on any mem_ready.
  - RESP -> IDLE unconditionally.
- REQ-020: On request accept, the block SHALL latch req_vpn, req_asid and satp_ppn; it SHALL ignore later changes to these inputs until IDLE is re-entered.
- REQ-021: In L1, mem_addr SHALL be {satp_ppn, vpn1, 2'b00}.
- REQ-022: In L0, mem_addr SHALL be {pte.ppn, vpn0, 2'b00}.
- REQ-023: mem_valid and mem_addr SHALL be registered, and SHALL be held stable from assertion until the cycle mem_ready is sampled high.
- REQ-024: PTE classification, bits V=0 R=1 W=2 X=3 U=4 G=5 A=6 D=7:
  - invalid: !V, or (!R && W) -> fault;
  - leaf: R|X;
  - otherwise pointer.
- REQ-025: A pointer PTE returned in L0 SHALL produce a fault.
- REQ-026: A leaf PTE returned in L1 whose ppn0 != 0 (misaligned superpage) SHALL produce a fault.
- REQ-027: For a megapage leaf, tlb_payload SHALL equal the PTE with ppn0 (bits 19:10) replaced by vpn0. All other bits, including G, SHALL pass through unchanged.
- REQ-028: In RESP, resp_valid SHALL be 1.
  - Success: tlb_we=1, resp_fault=0.
  - Fault: tlb_we=0, resp_fault=1.
- REQ-029: tlb_tag and tlb_payload SHALL be valid whenever tlb_we=1.
- REQ-030: Latency with zero-wait memory:
  - accept at edge 0;
  - mem_valid high in cycle 1 (L1) and cycle 2 (L0);
  - resp_valid in cycle 3.
  - Each memory wait cycle adds one cycle.
  - An L1 leaf or an L1 fault yields resp_valid in cycle 2.
- REQ-031: flush in IDLE SHALL have no effect.
- REQ-032: flush in L1 or L0 SHALL set an abort flag. The outstanding read SHALL still complete. The next state SHALL then be RESP with tlb_we=0 and resp_fault=0, and no further read SHALL be issued.
- REQ-033: flush in RESP SHALL suppress tlb_we; resp_valid SHALL still pulse.
- REQ-034: flush coincident with request accept SHALL be ignored for that accept.
- REQ-035: At most one walk SHALL be outstanding; req_ready SHALL be 0 from accept through RESP.

Reset
- REQ-036: Assertion of resetn low SHALL immediately force the following, regardless of clk:
  - state=IDLE;
  - mem_valid=0, tlb_we=0, resp_valid=0, resp_fault=0;
  - mem_addr=0, tlb_tag=0, tlb_payload=0;
  - abort flag=0.
- REQ-037: Reset mid-walk SHALL abandon the walk. No response SHALL be produced. Any late mem_ready SHALL be ignored in IDLE.

Configuration
- REQ-038: With SV32_PTW_SUPERPAGE_EN defined, L1 leaves SHALL be handled per REQ-026 and REQ-027.
- REQ-039: Without SV32_PTW_SUPERPAGE_EN, any L1 leaf SHALL produce a fault and no megapage logic SHALL be synthesised.

Structure
- REQ-040: Package sv32_pkg SHALL hold:
  - PTE bit-position constants;
  - width constants VPN=20, ASID=9, PPN=22, PA=34;
  - the FSM state enumeration;
  - the PTE-class enumeration {INVALID, POINTER, LEAF}.
- REQ-041: Sub-module sv32_pte_check SHALL be a combinational classifier: PTE in; class and misaligned-superpage flag out.

Verification
- REQ-042: satp_ppn=0x00001, vpn=0x00403, zero-wait memory; L1 returns 0x00000801, L0 returns 0x000020CF.
  - mem_addr: cycle 1 = 0x0000_1004, cycle 2 = 0x0000_200C.
  - Cycle 3: tlb_we=1, tlb_payload=0x000020CF.
- REQ-043: Same walk with L1 returning 0x00000000 -> resp_valid in cycle 2, resp_fault=1, tlb_we=0.
- REQ-044: With SV32_PTW_SUPERPAGE_EN, vpn=0x00803, L1 returns 0x200000EF -> tlb_payload=0x20000CEF, G=1 preserved.
- REQ-045: The same stimulus as REQ-044 without the macro -> resp_fault=1.
- REQ-046: flush pulsed during L1 with mem_ready delayed 3 cycles -> no L0 read, resp_valid=1, tlb_we=0, resp_fault=0.
- REQ-047: resetn low during L0 with mem_valid=1 -> mem_valid=0 immediately, req_ready=1 after release, and a subsequent walk completes correctly.

Source files
------------

// File: rtl/sv32_pkg.sv
// Shared constants and types for the Sv32 page-table walker: PTE bit positions,
// address widths, walker state and PTE classification.
package sv32_pkg;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   localparam int VPN_W  = 20;
   localparam int ASID_W = 9;
   localparam int PPN_W  = 22;
   localparam int PA_W   = 34;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_L1,
      ST_L0,
      ST_RESP
   } ptw_state_e;

   typedef enum logic [1:0] {
      PTE_INVALID,
      PTE_POINTER,
      PTE_LEAF
   } pte_class_e;

endpackage

// File: rtl/sv32_pte_check.sv
// Combinational PTE classifier: invalid / pointer / leaf, plus a flag for a
// superpage leaf whose low PPN field is non-zero.
module sv32_pte_check
   import sv32_pkg::*;
(
   input  logic [31:0] pte,
   output pte_class_e  pte_class,
   output logic        misaligned
);

   logic unused_bits;

   always_comb begin
      pte_class = PTE_POINTER;
      if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]))
         pte_class = PTE_INVALID;
      else if (pte[PTE_R] || pte[PTE_X])
         pte_class = PTE_LEAF;
   end

   assign misaligned  = |pte[19:10];
   assign unused_bits = ^{pte[31:20], pte[9:4]};

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 two-level hardware page-table walker feeding a TLB fill port.
// Define SV32_PTW_SUPERPAGE_EN to accept 4 MiB leaves found at level 1.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a TLB miss; req_ready high
// ST_L1   | level-1 PTE read outstanding at {satp_ppn, vpn1, 00}
// ST_L0   | level-0 PTE read outstanding at {pte.ppn, vpn0, 00}
// ST_RESP | one-cycle response; fill strobe on success
module sv32_ptw
   import sv32_pkg::*;
(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    flush,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [VPN_W-1:0]        req_vpn,
   input  logic [ASID_W-1:0]       req_asid,
   input  logic [PPN_W-1:0]        satp_ppn,
   output logic                    mem_valid,
   output logic [PA_W-1:0]         mem_addr,
   input  logic                    mem_ready,
   input  logic [31:0]             mem_rdata,
   output logic                    tlb_we,
   output logic [ASID_W+VPN_W-1:0] tlb_tag,
   output logic [31:0]             tlb_payload,
   output logic                    resp_valid,
   output logic                    resp_fault
);

   ptw_state_e        state;
   logic [VPN_W-1:0]  vpn_q;
   logic [ASID_W-1:0] asid_q;
   logic              abort_q;
   logic              fill_q;
   logic              abort_now;
   pte_class_e        pte_class;
   logic              pte_misaligned;
   logic              l1_leaf_ok;
   logic [31:0]       l1_leaf_payload;

   sv32_pte_check u_pte_check (
      .pte        (mem_rdata),
      .pte_class  (pte_class),
      .misaligned (pte_misaligned)
   );

`ifdef SV32_PTW_SUPERPAGE_EN
   assign l1_leaf_ok      = !pte_misaligned;
   assign l1_leaf_payload = {mem_rdata[31:20], vpn_q[9:0], mem_rdata[9:0]};
`else
   logic unused_misaligned;
   assign unused_misaligned = pte_misaligned;
   assign l1_leaf_ok        = 1'b0;
   assign l1_leaf_payload   = '0;
`endif

   // A flush in the same cycle the read completes aborts just like an earlier one.
   assign abort_now = abort_q | flush;
   assign req_ready = (state == ST_IDLE);
   // A flush arriving during the response cycle must still cancel the fill.
   assign tlb_we    = fill_q & ~flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         vpn_q       <= '0;
         asid_q      <= '0;
         abort_q     <= 1'b0;
         fill_q      <= 1'b0;
         mem_valid   <= 1'b0;
         mem_addr    <= '0;
         tlb_tag     <= '0;
         tlb_payload <= '0;
         resp_valid  <= 1'b0;
         resp_fault  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               abort_q <= 1'b0;
               if (req_valid) begin
                  vpn_q     <= req_vpn;
                  asid_q    <= req_asid;
                  mem_valid <= 1'b1;
                  mem_addr  <= {satp_ppn, req_vpn[19:10], 2'b00};
                  state     <= ST_L1;
               end
            end
            ST_L1: begin
               if (flush)
                  abort_q <= 1'b1;
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (!abort_now && pte_class == PTE_POINTER) begin
                     mem_valid <= 1'b1;
                     mem_addr  <= {mem_rdata[31:10], vpn_q[9:0], 2'b00};
                     state     <= ST_L0;
                  end else begin
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
                     if (!abort_now) begin
                        if (pte_class == PTE_LEAF && l1_leaf_ok) begin
                           fill_q      <= 1'b1;
                           tlb_tag     <= {asid_q, vpn_q};
                           tlb_payload <= l1_leaf_payload;
                        end else begin
                           resp_fault <= 1'b1;
                        end
                     end
                  end
               end
            end
            ST_L0: begin
               if (flush)
                  abort_q <= 1'b1;
               if (mem_ready) begin
                  mem_valid  <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
                  if (!abort_now) begin
                     if (pte_class == PTE_LEAF) begin
                        fill_q      <= 1'b1;
                        tlb_tag     <= {asid_q, vpn_q};
                        tlb_payload <= mem_rdata;
                     end else begin
                        resp_fault <= 1'b1;
                     end
                  end
               end
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               fill_q     <= 1'b0;
               abort_q    <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
